alu_sequencer: RTL and testbench

Sequential initiator for the combinational 8-bit ALU. Accepts operation requests over a valid/ready handshake, drives the ALU's `A`/`B`/`ALU_Sel` inputs from registers, and waits a programmable settle time. It then captures `ALU_Out` and the five status flags and returns them over a second valid/ready handshake. It sits between the control path and the ALU datapath, replacing direct combinational drive of the ALU.

---
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_sequencer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Sequential initiator for the combinational ALU: registered operand drive, programmable settle, captured response.
// Optional sticky-flag accumulator enabled by defining ALU_SEQ_STICKY_FLAGS_EN.
//
// state  | meaning
// S_IDLE | ready for a request; ALU operands hold their last values
// S_WAIT | ALU driven, counting down the settle time before capture
// S_RESP | captured result presented, waiting for the consumer
module alu_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_sel,
    input  logic             req_chain,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [3:0]       ALU_Sel,
    input  logic [WIDTH-1:0] ALU_Out,
    input  logic             CARRY,
    input  logic             BORROW,
    input  logic             OVERFLOW,
    input  logic             ZERO,
    input  logic             NEGATIVE,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [4:0]       rsp_flags,
    output logic             busy,
    output logic [15:0]      op_count
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    ,
    input  logic             clr_sticky,
    output logic [4:0]       sticky_flags
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] last_result;
    logic             accept;
    logic             capture;
    logic             handshake;
    logic [4:0]       flags_in;

    assign flags_in = {CARRY, BORROW, OVERFLOW, ZERO, NEGATIVE};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        handshake = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    handshake = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes, so nothing from the ALU reaches them combinationally.
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign rsp_valid = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A           <= '0;
            B           <= '0;
            ALU_Sel     <= '0;
            cnt         <= '0;
            rsp_data    <= '0;
            rsp_flags   <= '0;
            last_result <= '0;
            op_count    <= '0;
        end else begin
            if (accept) begin
                A       <= req_chain ? last_result : req_a;
                B       <= req_b;
                ALU_Sel <= req_sel;
                cnt     <= CNT_LOAD;
            end else if ((state == S_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                rsp_data    <= ALU_Out;
                rsp_flags   <= flags_in;
                last_result <= ALU_Out;
            end
            if (handshake) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
    // A clear coinciding with a capture keeps only the freshly captured flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (clr_sticky) begin
            sticky_flags <= capture ? flags_in : 5'd0;
        end else if (capture) begin
            sticky_flags <= sticky_flags | flags_in;
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (SETTLE=1 and SETTLE=3) on stub ALUs, checked against a
// transaction-level model every cycle, plus directed literal checks. Sticky checks need ALU_SEQ_STICKY_FLAGS_EN.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    logic       req_valid_s [2];
    logic       req_chain_s [2];
    logic       rsp_ready_s [2];
    logic [7:0] req_a_s     [2];
    logic [7:0] req_b_s     [2];
    logic [3:0] req_sel_s   [2];
    logic       req_ready_s [2];
    logic       rsp_valid_s [2];
    logic       busy_s      [2];
    logic [7:0] A_s         [2];
    logic [7:0] B_s         [2];
    logic [3:0] sel_s       [2];
    logic [7:0] rsp_data_s  [2];
    logic [4:0] rsp_flags_s [2];
    logic [15:0] op_count_s [2];
    logic [12:0] alu_s      [2];
`ifdef ALU_SEQ_STICKY_FLAGS_EN
    logic       clr_s       [2];
    logic [4:0] sticky_s    [2];
    logic [4:0] m_sticky    [2];
`endif

    int vectors = 0;
    int miscompares = 0;
    bit done = 1'b0;

    // Transaction-level model state
    int          cyc = 0;
    bit          m_out    [2];
    int          m_rsp_at [2];
    int          acc_cnt  [2];
    logic [7:0]  m_a      [2];
    logic [7:0]  m_b      [2];
    logic [3:0]  m_sel    [2];
    logic [7:0]  m_data   [2];
    logic [4:0]  m_flags  [2];
    logic [7:0]  m_last   [2];
    logic [15:0] m_count  [2];

    always #5 clk = ~clk;

    // Stub ALU: {CARRY,BORROW,OVERFLOW,ZERO,NEGATIVE,out}
    function automatic logic [12:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        logic [8:0] s;
        logic [7:0] o;
        logic c, bo, ov;
        c = 1'b0;
        bo = 1'b0;
        s = 9'd0;
        case (sel[1:0])
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[7:0];
                c = s[8];
            end
            2'd1: begin
                o = a - b;
                bo = (a < b);
            end
            2'd2: o = a & b;
            default: o = a ^ b;
        endcase
        ov = sel[3] & o[0];
        return {c, bo, ov, (o == 8'd0), o[7], o};
    endfunction

    function automatic int settle_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign alu_s[g] = alu_f(A_s[g], B_s[g], sel_s[g]);
        alu_sequencer #(.WIDTH(8), .SETTLE((g == 0) ? 1 : 3)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_valid (req_valid_s[g]),
            .req_ready (req_ready_s[g]),
            .req_a     (req_a_s[g]),
            .req_b     (req_b_s[g]),
            .req_sel   (req_sel_s[g]),
            .req_chain (req_chain_s[g]),
            .A         (A_s[g]),
            .B         (B_s[g]),
            .ALU_Sel   (sel_s[g]),
            .ALU_Out   (alu_s[g][7:0]),
            .CARRY     (alu_s[g][12]),
            .BORROW    (alu_s[g][11]),
            .OVERFLOW  (alu_s[g][10]),
            .ZERO      (alu_s[g][9]),
            .NEGATIVE  (alu_s[g][8]),
            .rsp_valid (rsp_valid_s[g]),
            .rsp_ready (rsp_ready_s[g]),
            .rsp_data  (rsp_data_s[g]),
            .rsp_flags (rsp_flags_s[g]),
            .busy      (busy_s[g]),
            .op_count  (op_count_s[g])
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            ,
            .clr_sticky   (clr_s[g]),
            .sticky_flags (sticky_s[g])
`endif
        );
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, i, $time, act, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 1'b0;
            m_rsp_at[i] = 0;
            m_a[i] = 8'd0;
            m_b[i] = 8'd0;
            m_sel[i] = 4'd0;
            m_data[i] = 8'd0;
            m_flags[i] = 5'd0;
            m_last[i] = 8'd0;
            m_count[i] = 16'd0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            m_sticky[i] = 5'd0;
`endif
        end
    endfunction

    // Model: a request is taken when no transaction is outstanding; its result is available SETTLE
    // edges later and retires on the first edge after that with rsp_ready high.
    initial begin
        m_reset();
        for (int i = 0; i < 2; i++) acc_cnt[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                cyc++;
                for (int i = 0; i < 2; i++) begin
                    if (!m_out[i]) begin
                        if (req_valid_s[i]) begin
                            m_a[i]   = req_chain_s[i] ? m_last[i] : req_a_s[i];
                            m_b[i]   = req_b_s[i];
                            m_sel[i] = req_sel_s[i];
                            {m_flags[i], m_data[i]} = alu_f(m_a[i], m_b[i], m_sel[i]);
                            m_rsp_at[i] = cyc + settle_of(i);
                            m_out[i] = 1'b1;
                            acc_cnt[i]++;
                        end
                    end else if (cyc > m_rsp_at[i] && rsp_ready_s[i]) begin
                        m_out[i] = 1'b0;
                        m_count[i] = m_count[i] + 16'd1;
                    end
                    if (m_out[i] && cyc == m_rsp_at[i]) m_last[i] = m_data[i];
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                    if (clr_s[i])
                        m_sticky[i] = (m_out[i] && cyc == m_rsp_at[i]) ? m_flags[i] : 5'd0;
                    else if (m_out[i] && cyc == m_rsp_at[i])
                        m_sticky[i] = m_sticky[i] | m_flags[i];
`endif
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("req_ready", i, 32'(req_ready_s[i]), 32'(!m_out[i]));
                chk("busy", i, 32'(busy_s[i]), 32'(m_out[i]));
                chk("rsp_valid", i, 32'(rsp_valid_s[i]), 32'(m_out[i] && cyc >= m_rsp_at[i]));
                if (m_out[i] && cyc >= m_rsp_at[i]) begin
                    chk("rsp_data", i, 32'(rsp_data_s[i]), 32'(m_data[i]));
                    chk("rsp_flags", i, 32'(rsp_flags_s[i]), 32'(m_flags[i]));
                end
                chk("op_count", i, 32'(op_count_s[i]), 32'(m_count[i]));
                chk("A", i, 32'(A_s[i]), 32'(m_a[i]));
                chk("B", i, 32'(B_s[i]), 32'(m_b[i]));
                chk("ALU_Sel", i, 32'(sel_s[i]), 32'(m_sel[i]));
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                chk("sticky", i, 32'(sticky_s[i]), 32'(m_sticky[i]));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel, input logic ch);
        int c0 = acc_cnt[i];
        int n = 0;
        req_a_s[i] = a;
        req_b_s[i] = b;
        req_sel_s[i] = sel;
        req_chain_s[i] = ch;
        req_valid_s[i] = 1'b1;
        while (acc_cnt[i] == c0 && n < 200) begin
            tick();
            n++;
        end
        req_valid_s[i] = 1'b0;
        chk("issue_accept", i, 32'(acc_cnt[i] != c0), 32'd1);
    endtask

    task automatic wait_valid(input int i);
        int n = 0;
        while (!rsp_valid_s[i] && n < 50) begin
            tick();
            n++;
        end
        chk("rsp_valid_wait", i, 32'(rsp_valid_s[i]), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid_s[i] = 1'b0;
            req_chain_s[i] = 1'b0;
            rsp_ready_s[i] = 1'b1;
            req_a_s[i] = 8'd0;
            req_b_s[i] = 8'd0;
            req_sel_s[i] = 4'd0;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            clr_s[i] = 1'b0;
`endif
        end
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", i, 32'(req_ready_s[i]), 32'd1);
            chk("rst_busy", i, 32'(busy_s[i]), 32'd0);
            chk("rst_rsp_valid", i, 32'(rsp_valid_s[i]), 32'd0);
            chk("rst_A", i, 32'(A_s[i]), 32'd0);
            chk("rst_rsp_data", i, 32'(rsp_data_s[i]), 32'd0);
            chk("rst_op_count", i, 32'(op_count_s[i]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Basic add, SETTLE=1: response one cycle after accept
        issue(0, 8'h0A, 8'h03, 4'd0, 1'b0);
        tick();
        chk("t1_valid", 0, 32'(rsp_valid_s[0]), 32'd1);
        chk("t1_data", 0, 32'(rsp_data_s[0]), 32'h0D);
        chk("t1_flags", 0, 32'(rsp_flags_s[0]), 32'b00000);
        tick();
        chk("t1_count", 0, 32'(op_count_s[0]), 32'd1);
        chk("t1_ready", 0, 32'(req_ready_s[0]), 32'd1);

        // Carry and zero
        issue(0, 8'hFF, 8'h01, 4'd0, 1'b0);
        tick();
        chk("t2_data", 0, 32'(rsp_data_s[0]), 32'h00);
        chk("t2_flags", 0, 32'(rsp_flags_s[0]), 32'b10010);
        tick();
        chk("t2_count", 0, 32'(op_count_s[0]), 32'd2);

        // Chained operand A uses the previous result, not req_a
        issue(0, 8'h0A, 8'h03, 4'd0, 1'b0);
        tick();
        tick();
        issue(0, 8'h55, 8'h03, 4'd0, 1'b1);
        tick();
        chk("t3_chain_data", 0, 32'(rsp_data_s[0]), 32'h10);
        tick();

        // Backpressure on the SETTLE=3 instance with a second request held pending
        rsp_ready_s[1] = 1'b0;
        issue(1, 8'h20, 8'h30, 4'd0, 1'b0);
        wait_valid(1);
        req_a_s[1] = 8'h11;
        req_b_s[1] = 8'h22;
        req_sel_s[1] = 4'd2;
        req_chain_s[1] = 1'b0;
        req_valid_s[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t4_valid", 1, 32'(rsp_valid_s[1]), 32'd1);
            chk("t4_data", 1, 32'(rsp_data_s[1]), 32'h50);
            chk("t4_ready_low", 1, 32'(req_ready_s[1]), 32'd0);
            tick();
        end
        rsp_ready_s[1] = 1'b1;
        tick();
        chk("t4_ready_after_hs", 1, 32'(req_ready_s[1]), 32'd1);
        chk("t4_count", 1, 32'(op_count_s[1]), 32'd1);
        tick();
        chk("t4_second_busy", 1, 32'(busy_s[1]), 32'd1);
        chk("t4_second_A", 1, 32'(A_s[1]), 32'h11);
        req_valid_s[1] = 1'b0;
        wait_valid(1);
        chk("t4_second_data", 1, 32'(rsp_data_s[1]), 32'h00);
        tick();
        tick();

        // Reset one cycle after accept, while still settling
        issue(1, 8'h40, 8'h01, 4'd0, 1'b0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 1, 32'(busy_s[1]), 32'd0);
        chk("t5_valid", 1, 32'(rsp_valid_s[1]), 32'd0);
        chk("t5_A", 1, 32'(A_s[1]), 32'd0);
        chk("t5_count", 1, 32'(op_count_s[1]), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t5_no_rsp", 1, 32'(rsp_valid_s[1]), 32'd0);
        end

`ifdef ALU_SEQ_STICKY_FLAGS_EN
        issue(0, 8'hFF, 8'h01, 4'd0, 1'b0);
        tick();
        tick();
        issue(0, 8'h01, 8'h01, 4'd0, 1'b0);
        tick();
        tick();
        chk("t6_sticky", 0, 32'(sticky_s[0]), 32'b10010);
        clr_s[0] = 1'b1;
        tick();
        clr_s[0] = 1'b0;
        chk("t6_sticky_clr", 0, 32'(sticky_s[0]), 32'b00000);
`endif

        // Randomized traffic with random consumer backpressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    int ri;
                    logic [7:0] ra, rb;
                    logic [3:0] rs;
                    logic rc;
                    ri = int'($urandom_range(0, 1));
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    rs = 4'($urandom);
                    rc = 1'($urandom_range(0, 1));
                    issue(ri, ra, rb, rs, rc);
                    if ($urandom_range(0, 3) == 0) tick();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    for (int i = 0; i < 2; i++) begin
                        rsp_ready_s[i] = ($urandom_range(0, 2) != 0);
`ifdef ALU_SEQ_STICKY_FLAGS_EN
                        clr_s[i] = ($urandom_range(0, 15) == 0);
`endif
                    end
                    tick();
                end
            end
        join

        for (int i = 0; i < 2; i++) begin
            rsp_ready_s[i] = 1'b1;
`ifdef ALU_SEQ_STICKY_FLAGS_EN
            clr_s[i] = 1'b0;
`endif
        end
        begin
            int n = 0;
            while ((m_out[0] || m_out[1]) && n < 100) begin
                tick();
                n++;
            end
            chk("drain", 0, 32'(m_out[0] || m_out[1]), 32'd0);
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
